// File: rtl/nios_led3_switch_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Default debounce length derives from the board clock and window.
package nios_led3_switch_debounce_pkg;

  localparam int unsigned NIOS_LED3_CLK_HZ      = 50_000_000;
  localparam int unsigned NIOS_LED3_DEBOUNCE_MS = 1;
  localparam int unsigned SW_WIDTH              = 10;

  localparam int unsigned DEF_DEBOUNCE_CYCLES =
    (NIOS_LED3_CLK_HZ / 1000) * NIOS_LED3_DEBOUNCE_MS;

  typedef struct packed {
    logic clean;
    logic rise;
    logic fall;
  } db_bit_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nios_led3_switch_debounce_if.sv
// Switch bundle between the pins, the debouncer and the PIO.
// master drives raw pins, slave returns the cleaned view.
interface nios_led3_switch_debounce_if #(
  parameter int WIDTH = 10
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

endinterface

// File: rtl/nios_led3_switch_debounce_bit.sv
// One switch bit: 2-flop sync, stability counter, clean level
// and registered rise/fall pulses aligned with the new level.
module nios_led3_debounce_bit
  import nios_led3_switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  db_bit_t          r_st;

  logic w_diff;
  logic w_done;

  assign w_diff = r_sync2 ^ r_st.clean;
  assign w_done = w_diff && (r_cnt == CNT_MAX);

  // synchronizer pair, nothing between the two flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // count consecutive disagreeing cycles; any agreement restarts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!w_diff || w_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // accept the new level and pulse the matching edge once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st <= '0;
    end else begin
      r_st.rise <= 1'b0;
      r_st.fall <= 1'b0;
      if (w_done) begin
        r_st.clean <= r_sync2;
        r_st.rise  <= r_sync2;
        r_st.fall  <= ~r_sync2;
      end
    end
  end

  assign o_clean = r_st.clean;
  assign o_rise  = r_st.rise;
  assign o_fall  = r_st.fall;

endmodule

// File: rtl/nios_led3_switch_debounce.sv
// Slide-switch conditioner feeding the PIO in_port:
// per-bit sync/debounce/edge plus an any-edge flag.
module nios_led3_switch_debounce
  import nios_led3_switch_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] w_edge;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  if (CNT_W < 1) begin : g_bad_width
    $error("counter width underflow");
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nios_led3_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (sw_raw[g]),
      .o_clean (sw_clean[g]),
      .o_rise  (sw_rise[g]),
      .o_fall  (sw_fall[g])
    );
  end

  // flag any accepted edge in the same cycle as its pulse
  always_comb begin
    w_edge     = sw_rise | sw_fall;
    sw_changed = |w_edge;
  end

endmodule

// File: tb/tb_nios_led3_switch_debounce.sv
// Randomized and directed bench for the switch debouncer,
// checked against a sliding-window history model.
module tb_nios_led3_switch_debounce;

  localparam int W = 10;
  localparam int N = 4;

  logic clk;
  logic reset_n;

  nios_led3_switch_debounce_if #(.WIDTH(W)) sw_if ();

  nios_led3_switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_if.sw_raw),
    .sw_clean   (sw_if.sw_clean),
    .sw_rise    (sw_if.sw_rise),
    .sw_fall    (sw_if.sw_fall),
    .sw_changed (sw_if.sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // raw values seen at each edge, newest first
  logic [W-1:0] hist[$];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic         m_chg;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_init();
    hist.delete();
    for (int i = 0; i < N + 2; i++) hist.push_back('0);
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_chg   = 1'b0;
  endtask

  // a bit flips once the N samples that have cleared the
  // two-stage sync all disagree with the current level
  task automatic model_edge(input logic [W-1:0] raw);
    logic all_diff;
    hist.push_front(raw);
    while (hist.size() > N + 2) void'(hist.pop_back());
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j < N + 2; j++)
        if (hist[j][b] == m_clean[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_clean[b] = ~m_clean[b];
        if (m_clean[b]) m_rise[b] = 1'b1;
        else            m_fall[b] = 1'b1;
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  task automatic step(input logic [W-1:0] raw);
    @(negedge clk);
    sw_if.sw_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    chk("clean", 32'(sw_if.sw_clean), 32'(m_clean));
    chk("rise", 32'(sw_if.sw_rise), 32'(m_rise));
    chk("fall", 32'(sw_if.sw_fall), 32'(m_fall));
    chk("changed", 32'(sw_if.sw_changed), 32'(m_chg));
  endtask

  // hold raw until clean reaches target; lat = edges after sampling
  task automatic measure(input  logic [W-1:0] raw,
                         input  logic [W-1:0] target,
                         output int           lat,
                         output logic [W-1:0] rise_c,
                         output logic [W-1:0] fall_c,
                         output logic         chg_c);
    lat    = -1;
    rise_c = '0;
    fall_c = '0;
    chg_c  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(raw);
      if (lat < 0 && sw_if.sw_clean == target) begin
        lat    = i;
        rise_c = sw_if.sw_rise;
        fall_c = sw_if.sw_fall;
        chg_c  = sw_if.sw_changed;
      end
    end
  endtask

  task automatic settle(input logic [W-1:0] raw);
    for (int i = 0; i < N + 4; i++) step(raw);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clean"}, 32'(sw_if.sw_clean), 32'h0);
    chk({tag, "_rise"}, 32'(sw_if.sw_rise), 32'h0);
    chk({tag, "_fall"}, 32'(sw_if.sw_fall), 32'h0);
    chk({tag, "_chg"}, 32'(sw_if.sw_changed), 32'h0);
  endtask

  int           lat;
  logic [W-1:0] rc;
  logic [W-1:0] fc;
  logic         cc;
  logic         bounce_rise;
  logic [W-1:0] cur;

  initial begin
    reset_n      = 1'b0;
    sw_if.sw_raw = 10'h3FF;
    model_init();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");

    @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_init();
    measure(10'h3FF, 10'h3FF, lat, rc, fc, cc);
    chk("lat_init", 32'(lat), 32'd5);
    chk("rise_init", 32'(rc), 32'h3FF);
    chk("chg_init", 32'(cc), 32'h1);

    settle(10'h3FE);
    measure(10'h3FF, 10'h3FF, lat, rc, fc, cc);
    chk("lat_b0", 32'(lat), 32'd5);
    chk("rise_b0", 32'(rc), 32'h001);

    settle(10'h3F7);
    bounce_rise = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step((i % 4 == 3) ? 10'h3F7 : 10'h3FF);
      bounce_rise |= sw_if.sw_rise[3];
    end
    chk("bounce_clean", 32'(sw_if.sw_clean[3]), 32'h0);
    chk("bounce_rise", 32'(bounce_rise), 32'h0);
    measure(10'h3FF, 10'h3FF, lat, rc, fc, cc);
    chk("lat_b3", 32'(lat), 32'd5);

    settle(10'h000);
    measure(10'h0A5, 10'h0A5, lat, rc, fc, cc);
    chk("lat_a5", 32'(lat), 32'd5);
    chk("rise_a5", 32'(rc), 32'h0A5);
    chk("fall_a5", 32'(fc), 32'h000);

    measure(10'h0A4, 10'h0A4, lat, rc, fc, cc);
    chk("fall_b0", 32'(fc), 32'h001);
    chk("rise_b0f", 32'(rc), 32'h000);

    for (int i = 0; i < 4; i++) step(10'h0A6);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_init();
    measure(10'h0A6, 10'h0A6, lat, rc, fc, cc);
    chk("lat_post", 32'(lat), 32'd5);
    chk("rise_post", 32'(rc), 32'h0A6);

    cur = 10'h0A6;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      step(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
